// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - register offsets, CTRL bit positions and responder FSM states
package bus_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PERIOD = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_AUTO  = 1;
  localparam int CTRL_IRQEN = 2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} bus_state_t;

endpackage

// File: rtl/timer_core.sv
// rtl/timer_core.sv - prescaler, down-counter, reload and expiry flag
module timer_core #(
  parameter int PRESCALE = 50
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        en,
  input  logic        auto,
  input  logic [15:0] period,
  input  logic        count_load,
  input  logic [15:0] load_data,
  input  logic        tick_block,
  input  logic        exp_clear,
  output logic [15:0] count,
  output logic        exp,
  output logic        en_clear
);

  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

  logic [15:0] presc;
  logic        tick;
  logic        expire;

  always_comb begin
    tick     = en & (presc == PRE_LAST) & ~tick_block;
    expire   = tick & (count == 16'd0);
    en_clear = expire & ~auto;
  end

  // The prescaler keeps wrapping on a blocked tick; only the count/flag effect is dropped.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      presc <= 16'd0;
    end else if (count_load) begin
      presc <= 16'd0;
    end else if (en) begin
      presc <= (presc == PRE_LAST) ? 16'd0 : presc + 16'd1;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      count <= 16'd0;
    end else if (count_load) begin
      count <= load_data;
    end else if (tick) begin
      if (count == 16'd0) begin
        if (auto) count <= period;
      end else begin
        count <= count - 16'd1;
      end
    end
  end

  // Expiry beats a simultaneous software clear.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      exp <= 1'b0;
    end else if (expire) begin
      exp <= 1'b1;
    end else if (exp_clear) begin
      exp <= 1'b0;
    end
  end

endmodule

// File: rtl/timer_responder.sv
// rtl/timer_responder.sv - bus responder interval timer; TIMER_IRQ_EN enables Irq and CTRL.IRQEN
module timer_responder
  import bus_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'hA000,
  parameter int          WAIT_CYCLES = 1,
  parameter int          PRESCALE    = 50
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Read,
  input  logic        Write,
  input  logic [15:0] Addr,
  input  logic [15:0] WrData,
  output logic [15:0] RdData,
  output logic        Done,
  output logic        Irq
);

  localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  bus_state_t  state, state_nxt;
  logic [3:0]  wait_cnt;
  logic [1:0]  off_q;
  logic        wr_q;
  logic [15:0] rdata_q;

  logic        hit, enter_resp;
  logic [1:0]  cur_off;
  logic        cur_wr;
  logic        wr_ctrl, wr_period, wr_count, wr_status;
  logic [15:0] rd_val;

  logic        en, auto, irqen;
  logic [15:0] period;
  logic [15:0] count_val;
  logic        exp, en_clear;

  assign hit = (Read | Write) && (Addr[15:2] == BASE_ADDR[15:2]);

  // With zero wait states the commit edge is also the sampling edge, so use live inputs.
  assign cur_off = (state == IDLE) ? Addr[1:0] : off_q;
  assign cur_wr  = (state == IDLE) ? Write     : wr_q;

  always_comb begin
    state_nxt  = state;
    enter_resp = 1'b0;
    unique case (state)
      IDLE: begin
        if (hit) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      off_q    <= 2'd0;
      wr_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && hit) begin
        off_q    <= Addr[1:0];
        wr_q     <= Write;
        wait_cnt <= WAIT_INIT;
      end else if (state == WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
    end
  end

  always_comb begin
    wr_ctrl   = enter_resp & cur_wr & (cur_off == REG_CTRL);
    wr_period = enter_resp & cur_wr & (cur_off == REG_PERIOD);
    wr_count  = enter_resp & cur_wr & (cur_off == REG_COUNT);
    wr_status = enter_resp & cur_wr & (cur_off == REG_STATUS);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      en     <= 1'b0;
      auto   <= 1'b0;
      irqen  <= 1'b0;
      period <= 16'd0;
    end else begin
      if (wr_ctrl) begin
        en    <= WrData[CTRL_EN];
        auto  <= WrData[CTRL_AUTO];
`ifdef TIMER_IRQ_EN
        irqen <= WrData[CTRL_IRQEN];
`else
        irqen <= 1'b0;
`endif
      end else if (en_clear) begin
        en <= 1'b0;
      end
      if (wr_period) period <= WrData;
    end
  end

  timer_core #(.PRESCALE(PRESCALE)) u_core (
    .Clock      (Clock),
    .Reset      (Reset),
    .en         (en),
    .auto       (auto),
    .period     (period),
    .count_load (wr_count),
    .load_data  (WrData),
    .tick_block (wr_ctrl & ~WrData[CTRL_EN]),
    .exp_clear  (wr_status & WrData[0]),
    .count      (count_val),
    .exp        (exp),
    .en_clear   (en_clear)
  );

  always_comb begin
    rd_val = 16'd0;
    case (cur_off)
      REG_CTRL:   rd_val = {13'd0, irqen, auto, en};
      REG_PERIOD: rd_val = period;
      REG_COUNT:  rd_val = count_val;
      REG_STATUS: rd_val = {15'd0, exp};
      default:    rd_val = 16'd0;
    endcase
  end

  // Holding zero outside RESP keeps RdData quiet without an output mux.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rdata_q <= 16'd0;
    end else if (enter_resp && !cur_wr) begin
      rdata_q <= rd_val;
    end else begin
      rdata_q <= 16'd0;
    end
  end

  assign RdData = rdata_q;
  assign Done   = (state == RESP);

`ifdef TIMER_IRQ_EN
  assign Irq = exp & irqen;
`else
  assign Irq = 1'b0;
`endif

endmodule

// File: tb/tb_timer_responder.sv
// tb/tb_timer_responder.sv - randomized self-checking bench for timer_responder
module tb_timer_responder;

  localparam logic [15:0] BASE = 16'hA000;
  localparam int W  = 1;
  localparam int PS = 2;
`ifdef TIMER_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Read = 1'b0;
  logic        Write = 1'b0;
  logic [15:0] Addr = 16'd0;
  logic [15:0] WrData = 16'd0;
  logic [15:0] RdData;
  logic        Done;
  logic        Irq;

  always #5 Clock = ~Clock;

  timer_responder #(.BASE_ADDR(BASE), .WAIT_CYCLES(W), .PRESCALE(PS)) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .Read   (Read),
    .Write  (Write),
    .Addr   (Addr),
    .WrData (WrData),
    .RdData (RdData),
    .Done   (Done),
    .Irq    (Irq)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Timer behaviour in register terms; phase = clocks elapsed since the prescaler restarted.
  bit          m_en, m_auto, m_irqen, m_exp;
  logic [15:0] m_period, m_count;
  int          m_phase;

  task automatic m_reset();
    m_en = 0; m_auto = 0; m_irqen = 0; m_exp = 0;
    m_period = 0; m_count = 0; m_phase = 0;
  endtask

  function automatic logic [15:0] m_read(input int off);
    case (off)
      0:       return {13'd0, m_irqen, m_auto, m_en};
      1:       return m_period;
      2:       return m_count;
      default: return {15'd0, m_exp};
    endcase
  endfunction

  task automatic m_step(input bit wr, input int off, input logic [15:0] d);
    bit tick = 0;
    bit n_en = m_en, n_auto = m_auto, n_irqen = m_irqen, n_exp = m_exp;
    logic [15:0] n_period = m_period, n_count = m_count;
    if (m_en) begin
      m_phase++;
      if (m_phase == PS) begin
        m_phase = 0;
        tick = 1;
      end
    end
    if (wr && off == 0 && !d[0]) tick = 0;
    if (tick) begin
      if (m_count == 0) begin
        n_exp = 1;
        if (m_auto) n_count = m_period;
        else n_en = 0;
      end else begin
        n_count = m_count - 16'd1;
      end
    end
    if (wr && off == 3 && d[0] && !(tick && m_count == 0)) n_exp = 0;
    if (wr) begin
      case (off)
        0: begin n_en = d[0]; n_auto = d[1]; n_irqen = IRQ & d[2]; end
        1: n_period = d;
        2: begin n_count = d; m_phase = 0; end
        default: ;
      endcase
    end
    m_en = n_en; m_auto = n_auto; m_irqen = n_irqen; m_exp = n_exp;
    m_period = n_period; m_count = n_count;
  endtask

  task automatic step(input bit wr, input int off, input logic [15:0] d);
    @(posedge Clock);
    m_step(wr, off, d);
    #1;
    check("irq", 16'(Irq), 16'(m_exp & m_irqen));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 16'd0);
  endtask

  task automatic do_reset();
    Reset = 0; Read = 0; Write = 0;
    @(posedge Clock);
    #1;
    Reset = 1;
    m_reset();
  endtask

  // kind: 0 read, 1 write, 2 read+write (acts as a write)
  task automatic txn(input int kind, input int off, input logic [15:0] d, output logic [15:0] rdata);
    logic [15:0] want;
    bit wr = (kind != 0);
    Read = (kind != 1); Write = wr; Addr = BASE + 16'(off); WrData = d;
    for (int k = 1; k <= W; k++) begin
      step(0, 0, 16'd0);
      check("done_early", 16'(Done), 16'd0);
    end
    want = wr ? 16'd0 : m_read(off);
    step(wr, off, d);
    check("done", 16'(Done), 16'd1);
    rdata = RdData;
    check($sformatf("rdata_off%0d", off), RdData, want);
    Read = 0; Write = 0;
    step(0, 0, 16'd0);
    check("done_pulse", 16'(Done), 16'd0);
    check("rdata_idle", RdData, 16'd0);
  endtask

  task automatic rd(input int off, output logic [15:0] data);
    txn(0, off, 16'd0, data);
  endtask

  task automatic wr(input int off, input logic [15:0] d);
    logic [15:0] dummy;
    txn(1, off, d, dummy);
  endtask

  task automatic auto_run(input int n, input logic [15:0] want_exp);
    logic [15:0] d;
    do_reset();
    wr(1, 16'd3);
    wr(2, 16'd3);
    wr(0, 16'h0003);
    idle(n);
    rd(3, d);
    check($sformatf("exp_at_c%0d", n + 3), d, want_exp);
  endtask

  initial begin
    logic [15:0] d;
    int t1, t2, k;
    bit seen;

    m_reset();
    repeat (3) @(posedge Clock);
    #1;
    check("rst_done", 16'(Done), 16'd0);
    check("rst_rdata", RdData, 16'd0);
    check("rst_irq", 16'(Irq), 16'd0);
    Reset = 1;

    rd(3, d);
    check("status_rst", d, 16'h0000);

    auto_run(5, 16'd0);
    auto_run(6, 16'd1);
    rd(2, d);
    check("count_reload", d, 16'd2);

    do_reset();
    wr(2, 16'd1);
    wr(0, 16'h0005);
    idle(8);
    rd(3, d);
    check("oneshot_exp", d, 16'd1);
    rd(0, d);
    check("oneshot_ctrl", d, IRQ ? 16'h0004 : 16'h0000);
    rd(2, d);
    check("oneshot_count", d, 16'd0);
    check("oneshot_irq", 16'(Irq), 16'(IRQ));

    do_reset();
    wr(2, 16'd1);
    wr(0, 16'h0001);
    idle(1);
    wr(3, 16'h0001);
    rd(3, d);
    check("clr_vs_expire", d, 16'd1);
    wr(3, 16'h0001);
    rd(3, d);
    check("clr_plain", d, 16'd0);

    Read = 1; Addr = BASE + 16'd4;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 16'd0);
      if (Done) seen = 1;
    end
    check("miss_done", 16'(seen), 16'd0);
    Read = 0;
    step(0, 0, 16'd0);

    Read = 1; Addr = BASE + 16'd3;
    t1 = -1; t2 = -1; k = 0;
    while (k < 20 && t2 < 0) begin
      step(0, 0, 16'd0);
      k++;
      if (Done) begin
        if (t1 < 0) t1 = k;
        else t2 = k;
      end
    end
    Read = 0;
    check("first_latency", 16'(t1), 16'(W + 1));
    check("b2b_gap", 16'(t2 - t1), 16'(W + 2));
    step(0, 0, 16'd0);

    do_reset();
    Write = 1; Addr = BASE + 16'd1; WrData = 16'h1234;
    step(0, 0, 16'd0);
    Reset = 0;
    #1;
    check("abort_done0", 16'(Done), 16'd0);
    repeat (2) @(posedge Clock);
    #1;
    check("abort_done1", 16'(Done), 16'd0);
    Write = 0; Reset = 1;
    m_reset();
    rd(1, d);
    check("abort_period", d, 16'h0000);

    do_reset();
    for (int it = 0; it < 150; it++) begin
      int kind, off;
      logic [15:0] v;
      kind = $urandom_range(0, 2);
      off  = $urandom_range(0, 3);
      case (off)
        0:       v = 16'($urandom_range(0, 7));
        3:       v = 16'($urandom_range(0, 1));
        default: v = 16'($urandom_range(0, 4));
      endcase
      txn(kind, off, v, d);
      idle($urandom_range(0, 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
